// File: rtl/irq_pkg.sv
// Shared constants for the interrupt front-end: opcodes, command/status field
// positions and the priority helper used when IRQ_PRIORITY_EN is defined.
package irq_pkg;

  localparam logic [1:0] OP_MASK  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_MODE  = 2'b10;
  localparam logic [1:0] OP_SET   = 2'b11;

  localparam int CMD_OP_HI = 7;
  localparam int CMD_OP_LO = 6;
  localparam int CMD_TGL   = 5;

  localparam int ST_ACK     = 7;
  localparam int ST_ANY     = 6;
  localparam int ST_MASK_LO = 3;
  localparam int ST_PEND_LO = 0;

  // Keeps only the highest-index set bit (line 2 outranks line 0).
  function automatic logic [2:0] hi_onehot(input logic [2:0] v);
    logic [2:0] r;
    if (v[2]) begin
      r = 3'b100;
    end else if (v[1]) begin
      r = 3'b010;
    end else if (v[0]) begin
      r = 3'b001;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_if.sv
// CPU-facing bundle of the interrupt front-end: raw requests, command port,
// status port and the forwarded interrupt lines.
interface irq_if #(
  parameter int N_IRQ = 3
);
  logic [N_IRQ-1:0] irq_in;
  logic [7:0]       cmd_port;
  logic [7:0]       status_port;
  logic [N_IRQ-1:0] irq_out;

  modport master (
    output irq_in,
    output cmd_port,
    input  status_port,
    input  irq_out
  );

  modport slave (
    input  irq_in,
    input  cmd_port,
    output status_port,
    output irq_out
  );
endinterface

// File: rtl/irq_sync_edge.sv
// One interrupt line: multi-flop synchroniser, previous-value flop and the
// edge/level event qualifier.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_irq,
  input  logic i_level,
  output logic o_event
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchroniser shift chain plus the one-cycle-delayed copy for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
      r_prev <= w_s;
    end
  end

  always_comb begin
    o_event = 1'b0;
    if (i_level) begin
      o_event = w_s;
    end else begin
      o_event = w_s & ~r_prev;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt front-end: synchronise, qualify, latch, mask and forward requests
// to the CPU. Optional IRQ_PRIORITY_EN forwards only the highest masked line.
module irq_controller
  import irq_pkg::*;
#(
  parameter int         N_IRQ       = 3,
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] MASK_RST    = 3'b111
) (
  input  logic clk,
  input  logic reset,
  irq_if.slave bus
);

  logic [1:0]       r_cmd_op;
  logic             r_cmd_tgl;
  logic [N_IRQ-1:0] r_cmd_opnd;
  logic             r_ack;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_mode;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_irq_out;

  logic [N_IRQ-1:0] w_event;
  logic             w_exec;
  logic [N_IRQ-1:0] w_mask_nxt;
  logic [N_IRQ-1:0] w_mode_nxt;
  logic [N_IRQ-1:0] w_pend_nxt;
  logic [N_IRQ-1:0] w_fwd;
  logic [N_IRQ-1:0] w_out_nxt;
  logic [2:0]       w_mask3;
  logic [2:0]       w_pend3;
  logic             w_any;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_irq   (bus.irq_in[g]),
      .i_level (r_mode[g]),
      .o_event (w_event[g])
    );
  end

  // Capture the CPU command port every cycle; reserved bits are not kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd_op   <= 2'b00;
      r_cmd_tgl  <= 1'b0;
      r_cmd_opnd <= '0;
    end else begin
      r_cmd_op   <= bus.cmd_port[CMD_OP_HI:CMD_OP_LO];
      r_cmd_tgl  <= bus.cmd_port[CMD_TGL];
      r_cmd_opnd <= bus.cmd_port[N_IRQ-1:0];
    end
  end

  // A command runs once whenever the captured toggle differs from ack.
  always_comb begin
    w_exec     = (r_cmd_tgl != r_ack);
    w_mask_nxt = r_mask;
    w_mode_nxt = r_mode;
    w_pend_nxt = r_pending;
    if (w_exec) begin
      case (r_cmd_op)
        OP_MASK:  w_mask_nxt = r_cmd_opnd;
        OP_CLEAR: w_pend_nxt = r_pending & ~r_cmd_opnd;
        OP_MODE:  w_mode_nxt = r_cmd_opnd;
        OP_SET:   w_pend_nxt = r_pending | r_cmd_opnd;
        default:  w_pend_nxt = r_pending;
      endcase
    end else begin
      w_pend_nxt = r_pending;
    end
    // Hardware events are applied last so they win over a same-cycle CLEAR.
    w_pend_nxt = w_pend_nxt | w_event;
  end

  always_comb begin
    w_fwd = r_pending & r_mask;
`ifdef IRQ_PRIORITY_EN
    begin
      logic [2:0] w_fwd3;
      logic [2:0] w_pri3;
      w_fwd3              = 3'b000;
      w_fwd3[N_IRQ-1:0]   = w_fwd;
      w_pri3              = hi_onehot(w_fwd3);
      w_out_nxt           = w_pri3[N_IRQ-1:0];
    end
`else
    w_out_nxt = w_fwd;
`endif
  end

  // Configuration, pending latch, handshake ack and the registered CPU lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack     <= 1'b0;
      r_mask    <= MASK_RST[N_IRQ-1:0];
      r_mode    <= '0;
      r_pending <= '0;
      r_irq_out <= '0;
    end else begin
      r_ack     <= r_cmd_tgl;
      r_mask    <= w_mask_nxt;
      r_mode    <= w_mode_nxt;
      r_pending <= w_pend_nxt;
      r_irq_out <= w_out_nxt;
    end
  end

  // Absent lines read back as zero in the status word.
  always_comb begin
    w_mask3            = 3'b000;
    w_pend3            = 3'b000;
    w_mask3[N_IRQ-1:0] = r_mask;
    w_pend3[N_IRQ-1:0] = r_pending;
    w_any              = |w_fwd;
  end

  always_comb begin
    bus.status_port                     = 8'h00;
    bus.status_port[ST_ACK]             = r_ack;
    bus.status_port[ST_ANY]             = w_any;
    bus.status_port[ST_MASK_LO +: 3]    = w_mask3;
    bus.status_port[ST_PEND_LO +: 3]    = w_pend3;
  end

  assign bus.irq_out = r_irq_out;

endmodule
